// File: rtl/pulse_ctrl_pkg.sv
// Shared definitions for the pulse window measurement controller:
// state encoding and default counter widths.
package pulse_ctrl_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_WIN_W  = 24;
  localparam int DEF_DEAD_W = 8;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    MEASURE = ST_MEASURE,
    DONE    = ST_DONE
  } state_t;

endpackage

// File: rtl/pulse_window_ctrl_dead_time.sv
// Non-paralyzable dead-time filter: after an accepted pulse, later pulses are
// rejected until the dead counter has run down to zero.
module pulse_dead_time_filter #(
  parameter int DEAD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic              pulse_in,
  input  logic [DEAD_W-1:0] dead_cyc,
  output logic              accept,
  output logic              reject
);

  logic [DEAD_W-1:0] dead_cnt;
  logic              dead_idle;

  assign dead_idle = (dead_cnt == '0);
  assign accept    = en & pulse_in & dead_idle;
  assign reject    = en & pulse_in & ~dead_idle;

  // Rejected pulses never reload the counter, so dead time is not extended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dead_cnt <= '0;
    end else if (clear) begin
      dead_cnt <= '0;
    end else if (en) begin
      if (accept)
        dead_cnt <= dead_cyc;
      else if (!dead_idle)
        dead_cnt <= dead_cnt - DEAD_W'(1);
    end
  end

endmodule

// File: rtl/pulse_window_ctrl.sv
// Windowed pulse counter: gates the pulse source for window_len cycles, counts
// accepted/dead-time-rejected pulses and returns them on a valid/ready port.
module pulse_window_ctrl
  import pulse_ctrl_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WIN_W  = DEF_WIN_W,
  parameter int DEAD_W = DEF_DEAD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WIN_W-1:0]  window_len,
  input  logic [DEAD_W-1:0] dead_cyc,
  input  logic              pulse_in,
  output logic              src_en,
  output logic              busy,
  output logic [CNT_W-1:0]  result_count,
  output logic [CNT_W-1:0]  result_dropped,
  output logic              result_ovf,
  output logic              result_valid,
  input  logic              result_ready
);

  // state   | meaning
  // IDLE    | waiting for start; results not valid
  // MEASURE | source enabled, window counting down, pulses filtered
  // DONE    | results held with result_valid until ready or abort
  state_t            state;
  logic [WIN_W-1:0]  win_cnt;
  logic [DEAD_W-1:0] dead_lat;
  logic              start_ok;
  logic              filt_en;
  logic              accept;
  logic              reject;

  assign start_ok = (state == IDLE) && start && !abort;
  assign filt_en  = (state == MEASURE) && !abort;

  pulse_dead_time_filter #(.DEAD_W(DEAD_W)) u_dead (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_ok),
    .en       (filt_en),
    .pulse_in (pulse_in),
    .dead_cyc (dead_lat),
    .accept   (accept),
    .reject   (reject)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      win_cnt        <= '0;
      dead_lat       <= '0;
      result_count   <= '0;
      result_dropped <= '0;
      result_ovf     <= 1'b0;
      src_en         <= 1'b0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            dead_lat       <= dead_cyc;
            result_count   <= '0;
            result_dropped <= '0;
            result_ovf     <= 1'b0;
            busy           <= 1'b1;
            if (window_len != '0) begin
              win_cnt <= window_len;
              src_en  <= 1'b1;
              state   <= MEASURE;
            end else begin
              result_valid <= 1'b1;
              state        <= DONE;
            end
          end
        end
        MEASURE: begin
          if (abort) begin
            src_en <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            win_cnt <= win_cnt - WIN_W'(1);
            if (accept) begin
              if (result_count == '1)
                result_ovf <= 1'b1;
              else
                result_count <= result_count + CNT_W'(1);
            end
            if (reject && result_dropped != '1)
              result_dropped <= result_dropped + CNT_W'(1);
            // Last window cycle still counts its pulse; results are complete next cycle.
            if (win_cnt == WIN_W'(1)) begin
              src_en       <= 1'b0;
              result_valid <= 1'b1;
              state        <= DONE;
            end
          end
        end
        DONE: begin
          if (abort || result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          src_en       <= 1'b0;
          busy         <= 1'b0;
          result_valid <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_window_ctrl.sv
// Scoreboard bench for pulse_window_ctrl: stimulus pushes expected results,
// a negedge monitor pops them on each completed handshake.
module tb_pulse_window_ctrl;

  localparam int CW = 4;
  localparam int WW = 24;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [WW-1:0] window_len;
  logic [DW-1:0] dead_cyc;
  logic          pulse_in;
  logic          src_en;
  logic          busy;
  logic [CW-1:0] result_count;
  logic [CW-1:0] result_dropped;
  logic          result_ovf;
  logic          result_valid;
  logic          result_ready;

  pulse_window_ctrl #(.CNT_W(CW), .WIN_W(WW), .DEAD_W(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .window_len     (window_len),
    .dead_cyc       (dead_cyc),
    .pulse_in       (pulse_in),
    .src_en         (src_en),
    .busy           (busy),
    .result_count   (result_count),
    .result_dropped (result_dropped),
    .result_ovf     (result_ovf),
    .result_valid   (result_valid),
    .result_ready   (result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int drp;
    int ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: results must hold while valid, and each handshake consumes one expectation.
  logic          was_valid = 1'b0;
  logic [CW-1:0] held_cnt, held_drp;
  logic          held_ovf;

  always @(negedge clk) begin
    if (!rst_n) begin
      was_valid = 1'b0;
    end else begin
      if (result_valid) begin
        if (!was_valid) begin
          held_cnt = result_count;
          held_drp = result_dropped;
          held_ovf = result_ovf;
        end else begin
          chk("hold_count", int'(result_count), int'(held_cnt));
          chk("hold_dropped", int'(result_dropped), int'(held_drp));
          chk("hold_ovf", int'(result_ovf), int'(held_ovf));
        end
        if (result_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result_count", int'(result_count), e.cnt);
            chk("result_dropped", int'(result_dropped), e.drp);
            chk("result_ovf", int'(result_ovf), e.ovf);
          end
        end
      end
      was_valid = result_valid;
    end
  end

  task automatic push(input int c, input int d, input int o);
    exp_t e;
    e.cnt = c;
    e.drp = d;
    e.ovf = o;
    sb.push_back(e);
  endtask

  // pat bit k = pulse level sampled in window cycle k (bit wl+1 is the first post-window cycle).
  task automatic run_meas(input int wl, input int dc, input logic [127:0] pat);
    window_len = WW'(wl);
    dead_cyc   = DW'(dc);
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= wl; k++) begin
      pulse_in = pat[k];
      chk("src_en_window", int'(src_en), 1);
      chk("busy_window", int'(busy), 1);
      tick();
    end
    pulse_in = pat[wl+1];
    chk("src_en_after", int'(src_en), 0);
    chk("valid_after", int'(result_valid), 1);
  endtask

  task automatic handshake(input int hold);
    for (int i = 0; i < hold; i++) begin
      tick();
      pulse_in = 1'b0;
      chk("valid_while_held", int'(result_valid), 1);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    pulse_in     = 1'b0;
    chk("valid_after_hs", int'(result_valid), 0);
    chk("busy_after_hs", int'(busy), 0);
  endtask

  initial begin
    logic [127:0] p;
    rst_n        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    window_len   = '0;
    dead_cyc     = '0;
    pulse_in     = 1'b0;
    result_ready = 1'b0;
    tick();
    tick();
    chk("rst_src_en", int'(src_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_ovf", int'(result_ovf), 0);
    chk("rst_count", int'(result_count), 0);
    chk("rst_dropped", int'(result_dropped), 0);
    rst_n = 1'b1;
    tick();

    // Pulses in window cycles 1, 5, 10 and in post-window cycle 11.
    p = '0;
    p[1] = 1'b1; p[5] = 1'b1; p[10] = 1'b1; p[11] = 1'b1;
    push(3, 0, 0);
    run_meas(10, 0, p);
    handshake(0);

    // Dead time 3, pulses in cycles 1..8: accept 1 and 5.
    p = '0;
    for (int k = 1; k <= 8; k++) p[k] = 1'b1;
    push(2, 6, 0);
    run_meas(20, 3, p);
    handshake(0);

    // Saturation at 15 with overflow; ready held off, start during DONE ignored.
    p = '1;
    push(15, 0, 1);
    run_meas(20, 0, p);
    tick();
    pulse_in   = 1'b0;
    window_len = WW'(5);
    start      = 1'b1;
    tick();
    start = 1'b0;
    chk("done_start_ignored_valid", int'(result_valid), 1);
    chk("done_start_ignored_src", int'(src_en), 0);
    handshake(3);

    // Abort in window cycle 4 of a 100-cycle window.
    window_len = WW'(100);
    dead_cyc   = '0;
    start      = 1'b1;
    tick();
    start    = 1'b0;
    pulse_in = 1'b1;
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort    = 1'b0;
    pulse_in = 1'b0;
    chk("abort_src_en", int'(src_en), 0);
    chk("abort_busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_valid", int'(result_valid), 0);
    end

    // Fresh measurement after abort: dead 1, pulses every cycle of 5.
    push(3, 2, 0);
    run_meas(5, 1, '1);
    handshake(1);

    // Zero-length window.
    push(0, 0, 0);
    run_meas(0, 0, '0);
    chk("zero_busy", int'(busy), 1);
    handshake(0);

    // Abort while DONE discards the result.
    run_meas(3, 0, '1);
    pulse_in = 1'b0;
    abort    = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_done_valid", int'(result_valid), 0);
    chk("abort_done_busy", int'(busy), 0);

    // Abort in IDLE blocks a simultaneous start.
    window_len = WW'(5);
    start      = 1'b1;
    abort      = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("idle_abort_blocks_start", int'(busy), 0);
    tick();

    // Async reset mid-measurement.
    window_len = WW'(50);
    start      = 1'b1;
    tick();
    start    = 1'b0;
    pulse_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_src_en", int'(src_en), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_src_en", int'(src_en), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_valid", int'(result_valid), 0);
    chk("arst_count", int'(result_count), 0);
    chk("arst_dropped", int'(result_dropped), 0);
    chk("arst_ovf", int'(result_ovf), 0);
    pulse_in = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_idle", int'(busy), 0);
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_window_ctrl.md
# pulse_window_ctrl

Measurement controller for the random pulse source. On command it enables the source for a programmable window of clock cycles and counts the source's pulses. It emulates detector dead time by rejecting pulses that arrive too soon after an accepted one. It then presents the accepted count, the rejected count and an overflow flag on a valid/ready result port. It sits between the pulse generator and the readout/host logic.

## Interface

Parameters:
- CNT_W, 16, width of the accepted and rejected pulse counters
- WIN_W, 24, width of the window length
- DEAD_W, 8, width of the dead-time length

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  start request; honoured only in IDLE
- abort  in  1  cancel the current measurement or pending result
- window_len  in  WIN_W  window length in cycles; sampled on accepted start
- dead_cyc  in  DEAD_W  dead time in cycles; sampled on accepted start
- pulse_in  in  1  pulse from the source; level sampled every cycle
- src_en  out  1  enable/gate to the pulse source
- busy  out  1  high in any state other than IDLE
- result_count  out  CNT_W  accepted pulses
- result_dropped  out  CNT_W  pulses rejected by dead time
- result_ovf  out  1  an accepted pulse arrived while result_count was at maximum
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts the result

## Operation

- States: IDLE, MEASURE, DONE.
- Reset values: IDLE; src_en, busy, result_valid and result_ovf are 0; both counters are 0; the window and dead-time counters are 0.
- IDLE with start=1 and window_len≠0:
  - Load the window counter with window_len and latch dead_cyc.
  - Clear both counters and ovf.
  - Go to MEASURE.
- IDLE with start=1 and window_len=0: clear the results and go straight to DONE. src_en is never asserted.
- MEASURE:
  - src_en=1.
  - Each cycle, decrement the window counter.
  - When the counter is 1 in the current cycle, go to DONE next cycle.
  - Each cycle with pulse_in=1 goes through the dead-time filter:
    - If the dead counter is 0, the pulse is accepted: increment result_count, or set ovf if it is already at max (saturating). Then load the dead counter with the latched dead_cyc.
    - Otherwise the pulse is rejected: increment result_dropped (saturating, no flag).
  - The dead counter decrements every cycle it is non-zero.
  - Non-paralyzable: a rejected pulse does not reload the dead counter.
  - dead_cyc=0 means every pulse is accepted.
- DONE:
  - src_en=0 and result_valid=1.
  - The results are held stable.
  - On result_valid && result_ready, go to IDLE next cycle.
- Ignored inputs:
  - start in MEASURE or DONE is ignored.
  - pulse_in outside MEASURE is ignored.
- abort:
  - In MEASURE or DONE, go to IDLE next cycle with src_en=0 and result_valid=0. Counters keep their values but are not valid.
  - abort has priority over the handshake and over window expiry.
  - abort in IDLE has no effect, and also blocks a simultaneous start.
- The dead counter is cleared on entry to MEASURE, so the first pulse of a window is always accepted.

## Timing

- start accepted in cycle T: src_en=1 and busy=1 from T+1 through T+window_len.
- Measurement window: pulses sampled in cycles T+1..T+window_len count, including the last window cycle.
- Results: result_valid=1 from T+window_len+1. result_count reflects all pulses up to and including cycle T+window_len.
- window_len=0: result_valid=1 at T+1 with all counts 0.
- Dead time: an accepted pulse at cycle t causes pulses at t+1..t+dead_cyc to be rejected. A pulse at t+dead_cyc+1 is accepted.
- Handshake: when ready is asserted in cycle H, result_valid=0 and busy=0 at H+1. The earliest next start is accepted at H+1.
- Asynchronous reset during MEASURE: src_en drops immediately; no result is produced.

## Structure

- Shared package pulse_ctrl_pkg holds:
  - the state encoding localparams (IDLE=2'd0, MEASURE=2'd1, DONE=2'd2)
  - the default widths CNT_W, WIN_W and DEAD_W
- One sub-module, pulse_dead_time_filter:
  - Contains the dead counter and the accept/reject decision.
  - Inputs: clk, rst_n, clear, en, pulse_in, dead_cyc.
  - Outputs: accept and reject strobes (combinational from the current dead counter and pulse_in).
- The top level holds the FSM, the window counter, the saturating counters and the output registers.

## Test plan

- window_len=10, dead_cyc=0, pulse_in high in window cycles 1, 5, 10 and also in cycle 11 → src_en high for 10 cycles; result_count=3, result_dropped=0; result_valid at T+11.
- window_len=20, dead_cyc=3, pulse_in high in window cycles 1–8 → accepted cycles 1 and 5 (count=2), dropped=6; cycle 9 would be accepted.
- CNT_W=4, window_len=20, pulse_in constantly high, dead_cyc=0 → result_count=15, result_ovf=1.
- result_ready held low for 5 cycles after valid, then asserted for one cycle → results stable throughout; IDLE one cycle later. A start issued during DONE is ignored.
- abort in MEASURE cycle 4 of window_len=100 → src_en=0, busy=0 next cycle; result_valid never asserted. A new start then produces fresh counts.
- window_len=0 → result_valid at T+1, counts 0, src_en never high. Also assert rst_n low mid-MEASURE → all outputs at reset values immediately.
